// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS core: one instruction fetched, decoded, executed and retired per clock.
// Instruction and data memories sit outside the core and are both read combinationally.
module mips_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] aluout,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_LUI = 3'd5;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    logic [31:0] r_regs [32];

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_signImm;
    logic [31:0] w_zeroImm;

    logic        w_regWrite;
    logic [1:0]  w_dstSel;
    logic        w_aluSrcImm;
    logic        w_zeroExt;
    logic [2:0]  w_aluCtl;
    logic        w_memToReg;
    logic        w_memWrite;
    logic        w_branchEq;
    logic        w_branchNe;
    logic        w_jump;
    logic        w_jumpReg;
    logic        w_link;

    logic [31:0] w_rsData;
    logic [31:0] w_rtData;
    logic [31:0] w_srcB;
    logic [31:0] w_aluResult;
    logic [4:0]  w_writeReg;
    logic [31:0] w_writeData;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_branchTarget;
    logic [31:0] w_jumpTarget;
    logic [31:0] w_pcNext;
    logic        w_unused;

    assign w_opcode  = instr[31:26];
    assign w_rs      = instr[25:21];
    assign w_rt      = instr[20:16];
    assign w_rd      = instr[15:11];
    assign w_funct   = instr[5:0];
    assign w_imm     = instr[15:0];
    assign w_signImm = {{16{w_imm[15]}}, w_imm};
    assign w_zeroImm = {16'h0000, w_imm};
    assign w_unused  = ^instr[10:6];

    // Main decoder: anything not listed decodes to all-zero controls, i.e. a NOP that only advances pc.
    always_comb begin
        w_regWrite  = 1'b0;
        w_dstSel    = DST_RT;
        w_aluSrcImm = 1'b0;
        w_zeroExt   = 1'b0;
        w_aluCtl    = ALU_ADD;
        w_memToReg  = 1'b0;
        w_memWrite  = 1'b0;
        w_branchEq  = 1'b0;
        w_branchNe  = 1'b0;
        w_jump      = 1'b0;
        w_jumpReg   = 1'b0;
        w_link      = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_dstSel = DST_RD;
                case (w_funct)
                    FN_ADD: begin w_regWrite = 1'b1; w_aluCtl = ALU_ADD; end
                    FN_SUB: begin w_regWrite = 1'b1; w_aluCtl = ALU_SUB; end
                    FN_AND: begin w_regWrite = 1'b1; w_aluCtl = ALU_AND; end
                    FN_OR:  begin w_regWrite = 1'b1; w_aluCtl = ALU_OR;  end
                    FN_SLT: begin w_regWrite = 1'b1; w_aluCtl = ALU_SLT; end
                    FN_JR:  w_jumpReg = 1'b1;
                    default: ;
                endcase
            end
            OP_LW: begin
                w_regWrite  = 1'b1;
                w_aluSrcImm = 1'b1;
                w_memToReg  = 1'b1;
            end
            OP_SW: begin
                w_aluSrcImm = 1'b1;
                w_memWrite  = 1'b1;
            end
            OP_BEQ: w_branchEq = 1'b1;
            OP_BNE: w_branchNe = 1'b1;
            OP_ADDI: begin
                w_regWrite  = 1'b1;
                w_aluSrcImm = 1'b1;
            end
            OP_ANDI: begin
                w_regWrite  = 1'b1;
                w_aluSrcImm = 1'b1;
                w_zeroExt   = 1'b1;
                w_aluCtl    = ALU_AND;
            end
            OP_ORI: begin
                w_regWrite  = 1'b1;
                w_aluSrcImm = 1'b1;
                w_zeroExt   = 1'b1;
                w_aluCtl    = ALU_OR;
            end
            OP_SLTI: begin
                w_regWrite  = 1'b1;
                w_aluSrcImm = 1'b1;
                w_aluCtl    = ALU_SLT;
            end
            OP_LUI: begin
                w_regWrite = 1'b1;
                w_aluCtl   = ALU_LUI;
            end
            OP_J: w_jump = 1'b1;
            OP_JAL: begin
                w_jump     = 1'b1;
                w_link     = 1'b1;
                w_regWrite = 1'b1;
                w_dstSel   = DST_RA;
            end
            default: ;
        endcase
    end

    // Register $0 is never written, so it is forced to zero on the read side.
    assign w_rsData = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign w_rtData = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];
    assign w_srcB   = w_aluSrcImm ? (w_zeroExt ? w_zeroImm : w_signImm) : w_rtData;

    always_comb begin
        case (w_aluCtl)
            ALU_ADD: w_aluResult = w_rsData + w_srcB;
            ALU_SUB: w_aluResult = w_rsData - w_srcB;
            ALU_AND: w_aluResult = w_rsData & w_srcB;
            ALU_OR:  w_aluResult = w_rsData | w_srcB;
            ALU_SLT: w_aluResult = ($signed(w_rsData) < $signed(w_srcB)) ? 32'd1 : 32'd0;
            ALU_LUI: w_aluResult = {w_imm, 16'h0000};
            default: w_aluResult = w_rsData + w_srcB;
        endcase
    end

    assign w_pcPlus4      = pc + 32'd4;
    assign w_branchTarget = w_pcPlus4 + {w_signImm[29:0], 2'b00};
    assign w_jumpTarget   = {w_pcPlus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        case (w_dstSel)
            DST_RD:  w_writeReg = w_rd;
            DST_RA:  w_writeReg = 5'd31;
            default: w_writeReg = w_rt;
        endcase
    end

    assign w_writeData = w_link ? w_pcPlus4 : (w_memToReg ? readdata : w_aluResult);

    always_comb begin
        w_pcNext = w_pcPlus4;
        if (w_jumpReg) begin
            w_pcNext = w_rsData;
        end else if (w_jump) begin
            w_pcNext = w_jumpTarget;
        end else if ((w_branchEq && (w_rsData == w_rtData)) ||
                     (w_branchNe && (w_rsData != w_rtData))) begin
            w_pcNext = w_branchTarget;
        end
    end

    // The regfile is deliberately not cleared by reset; the in-flight write is only suppressed.
    always_ff @(posedge clk) begin
        if (w_regWrite && !reset && (w_writeReg != 5'd0)) begin
            r_regs[w_writeReg] <= w_writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= w_pcNext;
        end
    end

    assign memwrite  = w_memWrite & ~reset;
    assign aluout    = w_aluResult;
    assign writedata = w_rtData;

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed programs plus a random program, all checked against an
// instruction-level interpreter of the MIPS subset that runs alongside the core.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;

    logic        e_mw;
    logic        e_av;
    logic [31:0] e_alu;
    logic [31:0] e_wd;
    logic [31:0] e_npc;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_val;

    int checkCount;
    int errorCount;

    mips_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    assign instr    = imem[pc[7:2]];
    assign readdata = dmem[aluout[7:2]];

    function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] encI(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] encJ(input int op, input int target);
        return {op[5:0], target[25:0]};
    endfunction

    // Interpreter: works out what the instruction at m_pc should show on the ports and commit.
    task automatic modelEval();
        logic [31:0] ins, a, b, se, ze, pc4;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic        iAlu;
        ins = imem[m_pc[7:2]];
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        a = m_regs[rs]; b = m_regs[rt]; pc4 = m_pc + 32'd4;
        e_mw = 1'b0; e_av = 1'b0; e_alu = 32'h0; e_wd = b; e_npc = pc4;
        e_rw = 1'b0; e_rd = 5'd0; e_val = 32'h0; iAlu = 1'b0;
        case (op)
            6'd0: begin
                case (fn)
                    6'd32: begin e_av = 1'b1; e_alu = a + b; end
                    6'd34: begin e_av = 1'b1; e_alu = a - b; end
                    6'd36: begin e_av = 1'b1; e_alu = a & b; end
                    6'd37: begin e_av = 1'b1; e_alu = a | b; end
                    6'd42: begin e_av = 1'b1; e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    6'd8:  e_npc = a;
                    default: ;
                endcase
                e_rw = e_av; e_rd = rd; e_val = e_alu;
            end
            6'd35: begin e_av = 1'b1; e_alu = a + se; e_rw = 1'b1; e_rd = rt; e_val = m_dmem[e_alu[7:2]]; end
            6'd43: begin e_av = 1'b1; e_alu = a + se; e_mw = 1'b1; end
            6'd4:  if (a == b) e_npc = pc4 + (se << 2);
            6'd5:  if (a != b) e_npc = pc4 + (se << 2);
            6'd8:  begin iAlu = 1'b1; e_alu = a + se; end
            6'd12: begin iAlu = 1'b1; e_alu = a & ze; end
            6'd13: begin iAlu = 1'b1; e_alu = a | ze; end
            6'd10: begin iAlu = 1'b1; e_alu = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'd15: begin iAlu = 1'b1; e_alu = {ins[15:0], 16'h0000}; end
            6'd2:  e_npc = {pc4[31:28], ins[25:0], 2'b00};
            6'd3:  begin e_npc = {pc4[31:28], ins[25:0], 2'b00}; e_rw = 1'b1; e_rd = 5'd31; e_val = pc4; end
            default: ;
        endcase
        if (iAlu) begin
            e_av = 1'b1; e_rw = 1'b1; e_rd = rt; e_val = e_alu;
        end
    endtask

    task automatic modelCommit();
        if (e_rw && (e_rd != 5'd0)) m_regs[e_rd] = e_val;
        if (e_mw) m_dmem[e_alu[7:2]] = e_wd;
        m_pc = e_npc;
    endtask

    // One clock: latch the store the core presents, advance the interpreter unless in reset.
    task automatic tick();
        logic        mwS;
        logic [31:0] adS, wdS;
        mwS = memwrite; adS = aluout; wdS = writedata;
        @(posedge clk);
        if (mwS === 1'b1) dmem[adS[7:2]] = wdS;
        if (reset) m_pc = 32'h0;
        else modelCommit();
        @(negedge clk);
    endtask

    task automatic clearImem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic startRun();
        reset = 1'b1;
        #1;
        m_pc = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] tr [3];
        tr = '{32'h0, 32'h4, 32'h8};
        clearImem();
        for (int k = 1; k < 32; k++) imem[k-1] = encI(8, 0, k, 0);
        #1;
        checkCount++;
        if (pc !== 32'h0) begin
            errorCount++; $display("FAIL reset_initial pc=%h expected=%h", pc, 32'h0);
        end
        startRun();
        for (int c = 0; c < 31; c++) begin
            modelEval();
            tick();
        end
        clearImem();
        imem[0] = encI(8, 0, 9, 32'h5A);
        startRun();
        for (int c = 0; c < 3; c++) begin
            modelEval();
            checkCount++;
            if (pc !== tr[c] || pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL reset_step cyc=%0d pc=%h expected=%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, tr[c], memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checkCount++;
        if (pc !== 32'h0) begin
            errorCount++; $display("FAIL reset_async pc=%h expected=%h", pc, 32'h0);
        end
        imem[0] = encI(43, 0, 9, 20);
        #1;
        checkCount++;
        if (memwrite !== 1'b0) begin
            errorCount++; $display("FAIL reset_memwrite_gate memwrite=%b expected=0", memwrite);
        end
        tick();
        checkCount++;
        if (dmem[5] !== 32'h0) begin
            errorCount++; $display("FAIL reset_store_commit dmem5=%h expected=%h", dmem[5], 32'h0);
        end
        imem[0] = encI(8, 9, 9, 1);
        imem[1] = encI(43, 0, 9, 8);
        #1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            modelEval();
            checkCount++;
            if (pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL reset_resume cyc=%0d pc=%h/%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, m_pc, memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            tick();
        end
        checkCount++;
        if (dmem[2] !== 32'h5B) begin
            errorCount++; $display("FAIL reset_regwrite_gate dmem2=%h expected=%h", dmem[2], 32'h5B);
        end
    endtask

    task automatic test_alu();
        logic [31:0] expMem [8];
        expMem = '{32'd7, 32'd1, 32'd4, 32'd13, 32'h8000_0000, 32'd1, 32'd0, 32'd0};
        clearImem();
        imem[0]  = encI(8, 0, 2, 5);
        imem[1]  = encI(8, 0, 3, 12);
        imem[2]  = encR(3, 2, 4, 34);
        imem[3]  = encR(2, 3, 5, 42);
        imem[4]  = encR(3, 2, 6, 36);
        imem[5]  = encR(3, 2, 7, 37);
        imem[6]  = encR(3, 2, 8, 42);
        imem[7]  = encI(15, 0, 10, 32'h7FFF);
        imem[8]  = encI(13, 10, 10, 32'hFFFF);
        imem[9]  = encI(8, 10, 11, 1);
        imem[10] = encI(10, 11, 12, 0);
        imem[11] = encR(11, 11, 13, 32);
        for (int k = 0; k < 8; k++) imem[12+k] = encI(43, 0, (k == 0) ? 4 : (k == 1) ? 5 : (k == 2) ? 6 :
                                                   (k == 3) ? 7 : (k == 4) ? 11 : (k == 5) ? 12 :
                                                   (k == 6) ? 13 : 8, 4*k);
        startRun();
        for (int c = 0; c < 20; c++) begin
            modelEval();
            checkCount++;
            if (pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL alu_step cyc=%0d pc=%h/%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, m_pc, memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            checkCount++;
            if (dmem[k] !== expMem[k]) begin
                errorCount++; $display("FAIL alu_result word=%0d got=%h expected=%h", k, dmem[k], expMem[k]);
            end
        end
    endtask

    task automatic test_memory();
        clearImem();
        imem[0] = encI(8, 0, 7, 7);
        imem[1] = encI(8, 0, 3, 12);
        imem[2] = encI(43, 3, 7, 68);
        imem[3] = encI(35, 0, 2, 80);
        imem[4] = encR(2, 0, 13, 32);
        imem[5] = encI(8, 0, 14, 100);
        imem[6] = encI(35, 14, 15, -20);
        imem[7] = encI(43, 14, 15, -4);
        startRun();
        for (int c = 0; c < 8; c++) begin
            modelEval();
            checkCount++;
            if (pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL mem_step cyc=%0d pc=%h/%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, m_pc, memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            if (c == 2) begin
                checkCount++;
                if (memwrite !== 1'b1 || aluout !== 32'd80 || writedata !== 32'd7) begin
                    errorCount++;
                    $display("FAIL mem_sw_ports mw=%b alu=%h wd=%h expected 1/%h/%h", memwrite, aluout, writedata, 32'd80, 32'd7);
                end
            end
            if (c == 4) begin
                checkCount++;
                if (aluout !== 32'd7) begin
                    errorCount++; $display("FAIL mem_lw_value alu=%h expected=%h", aluout, 32'd7);
                end
            end
            tick();
        end
        checkCount++;
        if (dmem[20] !== 32'd7 || dmem[24] !== 32'd7) begin
            errorCount++; $display("FAIL mem_contents w20=%h w24=%h expected=%h", dmem[20], dmem[24], 32'd7);
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] tr [10];
        tr = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h44, 32'h48, 32'h4C, 32'h4C};
        clearImem();
        imem[0]  = encI(8, 0, 1, 3);
        imem[1]  = encI(8, 0, 2, 3);
        imem[2]  = encI(4, 1, 2, 1);
        imem[3]  = encI(8, 0, 20, 32'hBAD);
        imem[4]  = encI(5, 1, 2, 5);
        imem[5]  = encI(8, 0, 21, 1);
        imem[6]  = encJ(2, 32'h11);
        imem[17] = encI(8, 0, 22, 32'h22);
        imem[18] = encI(43, 0, 20, 0);
        imem[19] = encI(4, 0, 0, -1);
        startRun();
        for (int c = 0; c < 10; c++) begin
            modelEval();
            checkCount++;
            if (pc !== tr[c] || pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL branch_step cyc=%0d pc=%h expected=%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, tr[c], memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            tick();
        end
        checkCount++;
        if (dmem[0] !== 32'h0) begin
            errorCount++; $display("FAIL branch_skipped_write dmem0=%h expected=%h", dmem[0], 32'h0);
        end
    endtask

    task automatic test_jal_jr();
        logic [31:0] tr [10];
        tr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h80, 32'h84, 32'h14, 32'h18, 32'h18};
        clearImem();
        imem[4]  = encJ(3, 32'h20);
        imem[5]  = encI(8, 0, 23, 32'h55);
        imem[6]  = encI(4, 0, 0, -1);
        imem[32] = encI(43, 0, 31, 32);
        imem[33] = encR(31, 0, 0, 8);
        startRun();
        for (int c = 0; c < 10; c++) begin
            modelEval();
            checkCount++;
            if (pc !== tr[c] || pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL jal_step cyc=%0d pc=%h expected=%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, tr[c], memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            if (c == 5) begin
                checkCount++;
                if (writedata !== 32'h14) begin
                    errorCount++; $display("FAIL jal_link wd=%h expected=%h", writedata, 32'h14);
                end
            end
            tick();
        end
        checkCount++;
        if (dmem[8] !== 32'h14) begin
            errorCount++; $display("FAIL jal_saved_ra dmem8=%h expected=%h", dmem[8], 32'h14);
        end
    endtask

    task automatic test_extended();
        logic [31:0] expMem [5];
        expMem = '{32'h1234_5678, 32'h0000_FFFF, 32'h0000_8000, 32'h0, 32'h66};
        clearImem();
        imem[0]  = encI(15, 0, 1, 32'h1234);
        imem[1]  = encI(13, 1, 1, 32'h5678);
        imem[2]  = encI(8, 0, 3, -1);
        imem[3]  = encI(12, 3, 4, 32'hFFFF);
        imem[4]  = encI(13, 0, 5, 32'h8000);
        imem[5]  = encI(8, 0, 0, 5);
        imem[6]  = encR(3, 3, 0, 32);
        imem[7]  = encI(8, 0, 6, 32'h66);
        imem[8]  = encI(63, 0, 6, 32'h1234);
        imem[9]  = encR(3, 3, 6, 39);
        imem[10] = encI(43, 0, 1, 0);
        imem[11] = encI(43, 0, 4, 4);
        imem[12] = encI(43, 0, 5, 8);
        imem[13] = encI(43, 0, 0, 12);
        imem[14] = encI(43, 0, 6, 16);
        startRun();
        for (int c = 0; c < 15; c++) begin
            modelEval();
            checkCount++;
            if (pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL ext_step cyc=%0d pc=%h/%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, pc, m_pc, memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            if (c == 3) begin
                checkCount++;
                if (aluout !== 32'h0000_FFFF) begin
                    errorCount++; $display("FAIL ext_andi_zeroext alu=%h expected=%h", aluout, 32'h0000_FFFF);
                end
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            checkCount++;
            if (dmem[k] !== expMem[k]) begin
                errorCount++; $display("FAIL ext_result word=%0d got=%h expected=%h", k, dmem[k], expMem[k]);
            end
        end
    endtask

    function automatic logic [31:0] randInstr();
        int k, rs, rt, rd, imm, off;
        logic [31:0] rw;
        k = int'($urandom_range(0, 19));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 65535));
        off = int'($urandom_range(0, 20)) - 10;
        rw = $urandom();
        case (k)
            0:  return encR(rs, rt, rd, 32);
            1:  return encR(rs, rt, rd, 34);
            2:  return encR(rs, rt, rd, 36);
            3:  return encR(rs, rt, rd, 37);
            4:  return encR(rs, rt, rd, 42);
            5:  return encR(rs, 0, 0, 8);
            6:  return encI(35, rs, rt, imm);
            7:  return encI(43, rs, rt, imm);
            8:  return encI(4, rs, rt, off);
            9:  return encI(5, rs, rt, off);
            10: return encI(8, rs, rt, imm);
            11: return encI(12, rs, rt, imm);
            12: return encI(13, rs, rt, imm);
            13: return encI(10, rs, rt, imm);
            14: return encI(15, 0, rt, imm);
            15: return encJ(2, int'($urandom_range(0, 63)));
            16: return encJ(3, int'($urandom_range(0, 63)));
            17: return {6'h3F, rw[25:0]};
            18: return encR(rs, rt, rd, 39);
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 64; i++) imem[i] = randInstr();
        startRun();
        for (int c = 0; c < 400; c++) begin
            modelEval();
            checkCount++;
            if (pc !== m_pc || memwrite !== e_mw || writedata !== e_wd || (e_av && aluout !== e_alu)) begin
                errorCount++;
                $display("FAIL random_step cyc=%0d ins=%h pc=%h/%h mw=%b/%b alu=%h/%h wd=%h/%h",
                         c, imem[m_pc[7:2]], pc, m_pc, memwrite, e_mw, aluout, e_alu, writedata, e_wd);
            end
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            checkCount++;
            if (dmem[k] !== m_dmem[k]) begin
                errorCount++; $display("FAIL random_dmem word=%0d got=%h expected=%h", k, dmem[k], m_dmem[k]);
            end
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        m_pc = 32'h0;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = 32'h0;
            m_dmem[i] = 32'h0;
            imem[i] = 32'h0;
        end
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        test_reset();
        test_alu();
        test_memory();
        test_branch_jump();
        test_jal_jr();
        test_extended();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
